// File: rtl/nds_ecc_ram_pkg.sv
// rtl/nds_ecc_ram_pkg.sv - shared types and defaults for the ECC RAM init/scrub controller
package nds_ecc_ram_pkg;

  localparam int ADDR_WIDTH_DEFAULT     = 5;
  localparam int DATA_WIDTH_DEFAULT     = 64;
  localparam int SCRUB_INTERVAL_DEFAULT = 1024;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_ctrl_state_e;

  typedef struct packed {
    logic                          cs;
    logic                          we;
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0] din;
  } ram_req_t;

endpackage

// File: rtl/nds_ecc_ram_scrub_timer.sv
// rtl/nds_ecc_ram_scrub_timer.sv - scrub interval timer, wrapping scrub pointer and scrub response flags
module nds_ecc_ram_scrub_timer
  import nds_ecc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int SCRUB_INTERVAL = SCRUB_INTERVAL_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ready,
  input  logic                  i_reinit,
  output logic                  o_slot,
  output logic [ADDR_WIDTH-1:0] o_ptr,
  output logic                  o_scrub_rvalid,
  output logic [ADDR_WIDTH-1:0] o_scrub_addr
);

  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] RELOAD = TW'(SCRUB_INTERVAL - 1);

  logic [TW-1:0]         timer_q, timer_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

  assign o_slot         = i_ready & pend_q;
  assign o_ptr          = ptr_q;
  assign o_scrub_rvalid = rvalid_q;
  assign o_scrub_addr   = raddr_q;

  // The timer is frozen while a scrub is pending so slots are spaced
  // SCRUB_INTERVAL host-usable cycles apart.
  always_comb begin
    timer_d  = timer_q;
    pend_d   = pend_q;
    ptr_d    = ptr_q;
    rvalid_d = o_slot;
    raddr_d  = o_slot ? ptr_q : raddr_q;
    if (o_slot) begin
      ptr_d = ptr_q + 1'b1;
    end
    if (i_ready) begin
      if (i_reinit) begin
        pend_d  = 1'b0;
        timer_d = RELOAD;
      end else if (pend_q) begin
        pend_d = 1'b0;
      end else if (timer_q == '0) begin
        pend_d  = 1'b1;
        timer_d = RELOAD;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_q  <= RELOAD;
      pend_q   <= 1'b0;
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      raddr_q  <= raddr_d;
    end
  end

endmodule

// File: rtl/nds_ecc_ram_init_ctrl.sv
// rtl/nds_ecc_ram_init_ctrl.sv - ECC RAM init sweep and host request forwarding; scrub reads under NDS_ECC_RAM_SCRUB_EN
module nds_ecc_ram_init_ctrl
  import nds_ecc_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int                    DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA      = '0,
  parameter int                    SCRUB_INTERVAL = SCRUB_INTERVAL_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_reinit,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_gnt,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_init_done,
  output logic                  o_scrub_rvalid,
  output logic [ADDR_WIDTH-1:0] o_scrub_addr,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  ram_ctrl_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  ready;
  logic                  scrub_slot;
  logic [ADDR_WIDTH-1:0] scrub_ptr;
  logic                  gnt, ram_cs, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  assign ready = (state_q == READY);

`ifdef NDS_ECC_RAM_SCRUB_EN
  nds_ecc_ram_scrub_timer #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_scrub_timer (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ready        (ready),
    .i_reinit       (i_reinit),
    .o_slot         (scrub_slot),
    .o_ptr          (scrub_ptr),
    .o_scrub_rvalid (o_scrub_rvalid),
    .o_scrub_addr   (o_scrub_addr)
  );
`else
  assign scrub_slot     = 1'b0;
  assign scrub_ptr      = '0;
  assign o_scrub_rvalid = 1'b0;
  assign o_scrub_addr   = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt      = 1'b0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state_q)
      INIT: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = INIT_DATA;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = READY;
        end
      end
      READY: begin
        gnt = i_req & ~scrub_slot;
        if (scrub_slot) begin
          ram_cs   = 1'b1;
          ram_addr = scrub_ptr;
        end else if (gnt) begin
          ram_cs   = 1'b1;
          ram_we   = i_we;
          ram_addr = i_addr;
          ram_din  = i_wdata;
        end
        if (i_reinit) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    rd_pend_d   = gnt & ~i_we;
    init_done_d = (state_d == READY);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // The reset state drives an init write, so the RAM pins are masked while
  // reset is held to present idle values until the first sweep edge.
  assign o_ram_cs    = ram_cs & ~i_rst;
  assign o_ram_we    = ram_we & ~i_rst;
  assign o_ram_addr  = i_rst ? '0 : ram_addr;
  assign o_ram_din   = i_rst ? '0 : ram_din;
  assign o_gnt       = gnt;
  assign o_rvalid    = rd_pend_q;
  assign o_rdata     = i_ram_dout;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_nds_ecc_ram_init_ctrl.sv
// tb/tb_nds_ecc_ram_init_ctrl.sv - randomized self-checking bench for nds_ecc_ram_init_ctrl with a RAM and scoreboard model
module tb_nds_ecc_ram_init_ctrl;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NW = 32;
  localparam int SI = 4;
  localparam logic [DW-1:0] INIT_PAT = 64'h5A5A_0F0F_C3C3_9696;
`ifdef NDS_ECC_RAM_SCRUB_EN
  localparam bit SCRUB_ON = 1'b1;
`else
  localparam bit SCRUB_ON = 1'b0;
`endif

  logic          clk, rst, reinit, h_req, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          o_gnt, o_rvalid, o_init_done, o_scrub_rvalid;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] o_scrub_addr;
  logic          o_ram_cs, o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] ram [NW];

  nds_ecc_ram_init_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_DATA(INIT_PAT), .SCRUB_INTERVAL(SI)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_reinit(reinit), .i_req(h_req), .i_we(h_we),
    .i_addr(h_addr), .i_wdata(h_wdata), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_init_done(o_init_done), .o_scrub_rvalid(o_scrub_rvalid),
    .o_scrub_addr(o_scrub_addr), .o_ram_cs(o_ram_cs), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_ram_cs) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
      else          ram_dout <= ram[o_ram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_scrub_seen = 0;
  int n_gnt_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit            m_init, m_done, m_rdv, m_scv;
  int            m_cnt, m_since, m_ptr, m_scaddr;
  logic [DW-1:0] m_rdd, m_scd;
  logic [DW-1:0] m_mem [NW];

  task automatic model_reset();
    m_init = 1; m_done = 0; m_rdv = 0; m_scv = 0;
    m_cnt = 0; m_since = 0; m_ptr = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_gnt", 64'(o_gnt), 0);
    check("rst_rvalid", 64'(o_rvalid), 0);
    check("rst_init_done", 64'(o_init_done), 0);
    check("rst_scrub_rvalid", 64'(o_scrub_rvalid), 0);
    check("rst_scrub_addr", 64'(o_scrub_addr), 0);
    check("rst_ram_cs", 64'(o_ram_cs), 0);
    check("rst_ram_we", 64'(o_ram_we), 0);
    check("rst_ram_addr", 64'(o_ram_addr), 0);
    check("rst_ram_din", o_ram_din, 0);
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, then advances the model over the edge.
  task automatic cycle();
    bit slot, gnt;
    #1;
    slot = SCRUB_ON && !m_init && (m_since == SI);
    gnt  = !m_init && h_req && !slot;
    check("gnt", 64'(o_gnt), 64'(gnt));
    check("init_done", 64'(o_init_done), 64'(m_done));
    check("rvalid", 64'(o_rvalid), 64'(m_rdv));
    if (m_rdv) check("rdata", o_rdata, m_rdd);
    check("scrub_rvalid", 64'(o_scrub_rvalid), 64'(m_scv));
    if (m_scv) begin
      check("scrub_addr", 64'(o_scrub_addr), 64'(m_scaddr));
      check("scrub_rdata", o_rdata, m_scd);
    end
    if (o_scrub_rvalid) n_scrub_seen++;
    if (!m_init && h_req && !o_gnt) n_gnt_miss++;
    if (m_init) begin
      check("init_cs", 64'(o_ram_cs), 1);
      check("init_we", 64'(o_ram_we), 1);
      check("init_addr", 64'(o_ram_addr), 64'(m_cnt));
      check("init_din", o_ram_din, INIT_PAT);
    end else if (slot) begin
      check("scrub_cs", 64'(o_ram_cs), 1);
      check("scrub_we", 64'(o_ram_we), 0);
      check("scrub_ram_addr", 64'(o_ram_addr), 64'(m_ptr));
    end else if (gnt) begin
      check("host_cs", 64'(o_ram_cs), 1);
      check("host_we", 64'(o_ram_we), 64'(h_we));
      check("host_addr", 64'(o_ram_addr), 64'(h_addr));
      if (h_we) check("host_din", o_ram_din, h_wdata);
    end else begin
      check("idle_cs", 64'(o_ram_cs), 0);
    end

    m_rdv = gnt && !h_we;
    if (m_rdv) m_rdd = m_mem[h_addr];
    m_scv = slot;
    if (slot) begin
      m_scaddr = m_ptr;
      m_scd    = m_mem[m_ptr];
      m_ptr    = (m_ptr + 1) % NW;
    end
    if (m_init) begin
      m_mem[m_cnt] = INIT_PAT;
      if (m_cnt == NW - 1) begin m_init = 0; m_done = 1; end
      m_cnt   = (m_cnt + 1) % NW;
      m_since = 0;
    end else begin
      if (gnt && h_we) m_mem[h_addr] = h_wdata;
      if (reinit) begin
        m_init = 1; m_cnt = 0; m_done = 0; m_since = 0;
      end else if (slot) m_since = 0;
      else m_since++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_host(input int req_pct);
    h_req   = ($urandom_range(0, 99) < req_pct);
    h_we    = 1'($urandom);
    h_addr  = AW'($urandom);
    h_wdata = {$urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1; reinit = 0; h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 0;

    // Sweep with requests held high
    for (int i = 0; i < NW; i++) begin
      rand_host(100);
      cycle();
    end
    check("init_done_cycle33", 64'(o_init_done), 1);

    // Directed write then read of address 7
    h_req = 1; h_we = 1; h_addr = 5'd7; h_wdata = 64'hDEAD;
    cycle();
    h_we = 0;
    cycle();
    h_req = 0;
    #1;
    check("rd7_rvalid", 64'(o_rvalid), 1);
    check("rd7_rdata", o_rdata, 64'hDEAD);
    @(posedge clk); #1;
    m_rdv = 0;

`ifdef NDS_ECC_RAM_SCRUB_EN
    // Continuous host reads with scrub slots interleaved; covers pointer wrap
    n_scrub_seen = 0;
    for (int i = 0; i < 200; i++) begin
      h_req = 1; h_we = 0; h_addr = AW'($urandom);
      cycle();
    end
    check("scrub_wrap_seen", 64'(n_scrub_seen >= 33), 1);

    // Reinit in the same cycle as a scrub slot
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      h_req = 1; h_we = 0; h_addr = AW'($urandom);
      if (!m_init && m_since == SI) begin reinit = 1; found = 1; end
      cycle();
      reinit = 0;
    end
    check("reinit_on_slot_found", 64'(found), 1);
    for (int i = 0; i < 40; i++) begin
      rand_host(80);
      cycle();
    end
`endif

    // Random traffic with occasional reinit
    for (int i = 0; i < 600; i++) begin
      rand_host(75);
      reinit = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reinit = 0;

    // Async reset at sweep address 12
    h_req = 0;
    for (int i = 0; i < 120 && !(m_init && m_cnt == 12); i++) begin
      reinit = !m_init;
      cycle();
    end
    reinit = 0;
    check("reached_sweep_addr12", 64'(m_init && m_cnt == 12), 1);
    #1;
    check("sweep_addr12", 64'(o_ram_addr), 12);
    rst = 1;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      rand_host(80);
      cycle();
    end

`ifndef NDS_ECC_RAM_SCRUB_EN
    n_gnt_miss = 0;
    n_scrub_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      rand_host(100);
      cycle();
    end
    check("noscrub_gnt_miss", 64'(n_gnt_miss), 0);
    check("noscrub_rvalid_seen", 64'(n_scrub_seen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
